// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that writes instruction RAM and gates CPU reset
module imem_loader #(
    parameter int         MEM_SIZE = 128,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        start,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERROR
    } state_t;

    localparam logic [15:0] MEM_WORDS = 16'(MEM_SIZE);

    state_t      state, state_nxt;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [7:0]  chk;
    logic [23:0] shift;
    logic        accept;

    assign accept   = in_valid && in_ready;
    assign len_full = {len[15:8], in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_HDR;
            S_HDR: begin
                in_ready = 1'b1;
                if (accept && in_data == HDR_BYTE) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (accept) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (len_full > MEM_WORDS)  state_nxt = S_ERROR;
                    else if (len_full == '0)   state_nxt = S_CHK;
                    else                       state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (accept && byte_cnt == 2'd3 && (word_idx + 16'd1) == len)
                    state_nxt = S_CHK;
            end
            S_CHK: begin
                in_ready = 1'b1;
                if (accept) state_nxt = (in_data == chk) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (start) state_nxt = S_HDR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status flags follow the next state so they change on the very edge that enters DONE/ERROR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            len       <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            chk       <= '0;
            shift     <= '0;
        end else begin
            we        <= 1'b0;
            done      <= (state_nxt == S_DONE);
            cpu_rst_n <= (state_nxt == S_DONE);
            err       <= (state_nxt == S_ERROR);
            case (state)
                S_LEN_HI: if (accept) len[15:8] <= in_data;
                S_LEN_LO: if (accept) len[7:0]  <= in_data;
                S_DATA: begin
                    if (accept) begin
                        chk      <= chk ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            we       <= 1'b1;
                            wdata    <= {shift, in_data};
                            waddr    <= {14'd0, word_idx, 2'b00};
                            word_idx <= word_idx + 16'd1;
                        end else begin
                            shift <= {shift[15:0], in_data};
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        len      <= '0;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        chk      <= '0;
                        shift    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        start = 1'b0;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  frame_q[$];

    imem_loader #(.MEM_SIZE(128), .HDR_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .start(start), .we(we), .waddr(waddr), .wdata(wdata),
        .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("we_unexpected", {31'd0, we}, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check_eq("waddr", waddr, e[63:32]);
                check_eq("wdata", wdata, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit stall);
        foreach (frame_q[i]) begin
            send_byte(frame_q[i]);
            if (stall) @(posedge clk);
        end
    endtask

    task automatic load_happy();
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
                    8'h01, 8'h09, 8'h50, 8'h20, 8'h51};
        exp_q.push_back({32'd0, 32'h24080005});
        exp_q.push_back({32'd4, 32'h01095020});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic c);
        check_eq({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check_eq({tag, "_err"}, {31'd0, err}, {31'd0, e});
        check_eq({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, c});
    endtask

    task automatic check_sb_empty(input string tag);
        @(negedge clk);
        @(negedge clk);
        check_eq({tag, "_pending_writes"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check_eq({tag, "_we"}, {31'd0, we}, 32'd0);
        check_eq({tag, "_waddr"}, waddr, 32'd0);
        check_eq({tag, "_wdata"}, wdata, 32'd0);
        check_status(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Happy path
        load_happy();
        send_frame(1'b0);
        check_status("happy", 1'b1, 1'b0, 1'b1);
        check_sb_empty("happy");
        pulse_start();
        check_status("rearm1", 1'b0, 1'b0, 1'b0);

        // Bad checksum
        load_happy();
        frame_q[frame_q.size()-1] = 8'h00;
        send_frame(1'b0);
        check_status("badchk", 1'b0, 1'b1, 1'b0);
        check_eq("badchk_in_ready", {31'd0, in_ready}, 32'd0);
        check_sb_empty("badchk");
        pulse_start();

        // Oversize length
        frame_q = '{8'hA5, 8'h00, 8'h81};
        send_frame(1'b0);
        check_status("oversize", 1'b0, 1'b1, 1'b0);
        check_sb_empty("oversize");
        pulse_start();

        // Zero length
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(1'b0);
        check_status("zerolen", 1'b1, 1'b0, 1'b1);
        check_sb_empty("zerolen");

        // Start collides with a valid header byte while in DONE
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check_status("collide", 1'b0, 1'b0, 1'b0);
        check_eq("collide_in_ready", {31'd0, in_ready}, 32'd1);
        load_happy();
        send_frame(1'b0);
        check_status("collide_load", 1'b1, 1'b0, 1'b1);
        check_sb_empty("collide_load");
        pulse_start();

        // Garbage before header, then stalled frame
        frame_q = '{8'hFF, 8'h12};
        send_frame(1'b0);
        load_happy();
        send_frame(1'b1);
        check_status("stall", 1'b1, 1'b0, 1'b1);
        check_sb_empty("stall");
        pulse_start();

        // Reset after the 6th data byte of a 2-word frame
        load_happy();
        exp_q.pop_back();
        for (int i = 0; i < 9; i++) send_byte(frame_q[i]);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check_sb_empty("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("release_idle_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("release_hdr_ready", {31'd0, in_ready}, 32'd1);
        load_happy();
        send_frame(1'b0);
        check_status("reload", 1'b1, 1'b0, 1'b1);
        check_sb_empty("reload");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Issues one-cycle write strobes to a writable instruction RAM. The RAM is word-addressed by address[31:2], the same addressing the CPU fetch path uses.
- Holds the processor in reset until a complete, checksum-valid program has been written.

Parameters:
- MEM_SIZE, 128, number of 32-bit words in instruction memory; maximum accepted word count.
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept a byte
- start  input  1  one-cycle pulse; re-arms loader from DONE or ERROR
- we  output  1  instruction memory write strobe
- waddr  output  32  byte address of write, always word-aligned
- wdata  output  32  instruction word to write
- cpu_rst_n  output  1  processor reset, active-low, low while loading
- done  output  1  program loaded successfully
- err  output  1  frame rejected

Behaviour:
- Reset: rst_n low asynchronously forces we=0, waddr=0, wdata=0, cpu_rst_n=0, done=0, err=0, in_ready=0.
  - State goes to IDLE; byte and word counters, length, checksum and shift register are cleared.
  - Memory contents already written are not touched.
- Byte acceptance: a byte is accepted on a rising edge with in_valid && in_ready. in_ready is a decode of state: 1 in HDR, LEN_HI, LEN_LO, DATA, CHK; 0 in IDLE, DONE, ERROR.
- State transitions:
  - IDLE -> HDR unconditionally after one cycle.
  - HDR: accepted byte == HDR_BYTE -> LEN_HI. Any other byte is discarded; stay in HDR.
  - LEN_HI: accepted byte -> len[15:8] -> LEN_LO.
  - LEN_LO: accepted byte -> len[7:0]. Then:
    - len > MEM_SIZE -> ERROR.
    - len == 0 -> CHK.
    - otherwise -> DATA.
  - DATA: bytes shift in MSB first (byte 0 -> wdata[31:24], byte 3 -> wdata[7:0]). All data bytes are XOR-accumulated into an 8-bit checksum.
    - On acceptance of the 4th byte of a word: next edge registers wdata, sets waddr = word_idx*4, and asserts we for exactly one cycle.
    - word_idx increments. When word_idx reaches len -> CHK.
    - in_ready stays 1 during the write cycle (zero-bubble streaming, 1 byte/cycle sustained).
  - CHK: accepted byte == accumulated XOR -> DONE, else -> ERROR. For len==0 the expected checksum is 8'h00.
  - DONE: done=1, cpu_rst_n=1, both registered and rising on the edge that enters DONE. The last we has always completed before DONE.
  - ERROR: err=1, cpu_rst_n=0.
  - DONE/ERROR + start -> HDR. That edge clears done/err, drives cpu_rst_n=0, and clears counters and checksum.
  - start in any other state is ignored.
- Simultaneous start and in_valid in DONE/ERROR: the byte is not accepted (in_ready=0); only the start takes effect.
- in_valid deasserted mid-word: partial word is held; no timeout.
- waddr never exceeds (MEM_SIZE-1)*4; no wrap-around is possible because len is bounded at LEN_LO.
- Reset mid-load: abort immediately; restart from IDLE; cpu_rst_n stays 0.

Test Plan:
- Happy path: stream A5 00 02 | 24 08 00 05 | 01 09 50 20 | chk 0x51, one byte/cycle.
  - Required: we pulses twice, (waddr=0, wdata=32'h24080005) then (waddr=4, wdata=32'h01095020).
  - Required: done=1, cpu_rst_n=1 on the edge accepting 0x51; err=0.
- Bad checksum: same frame with final byte 0x00.
  - Required: two writes occur, then err=1, done=0, cpu_rst_n=0, in_ready=0.
- Oversize/zero length:
  - A5 00 81 -> err=1 right after the third byte, no we.
  - A5 00 00 00 -> done=1, no we.
- Garbage and stalls: bytes FF 12 before A5, then frame from test 1 with in_valid toggled every other cycle.
  - Required: garbage discarded; identical writes and done as test 1.
- Re-arm/collision: in DONE, pulse start in the same cycle as in_valid=1, data=A5.
  - Required: A5 not consumed; state HDR; done=0, cpu_rst_n=0. A following full frame loads correctly.
- Reset mid-frame: assert rst_n=0 after the 6th data byte of a 2-word frame.
  - Required: all outputs return to reset values asynchronously.
  - Required: after release, in_ready=0 for one cycle, then 1; a new frame loads from waddr=0.
